// File: rtl/complex_mac_dpu_pkg.sv
// Shared opcode/mode constants and instruction payload decoding for the
// complex MAC datapath unit.
package complex_mac_dpu_pkg;

    localparam logic [2:0] OP_FSM = 3'd2;
    localparam logic [2:0] OP_DPU = 3'd3;

    localparam logic [4:0] MODE_NOP = 5'd0;
    localparam logic [4:0] MODE_ADD = 5'd1;
    localparam logic [4:0] MODE_SUB = 5'd2;
    localparam logic [4:0] MODE_MUL = 5'd7;
    localparam logic [4:0] MODE_MAC = 5'd10;

    localparam int DELAY_W    = 7;
    localparam int NUM_DELAYS = 3;

    typedef struct packed {
        logic [1:0]  option;
        logic [4:0]  mode;
        logic [15:0] imm;
    } dpu_t;

    typedef struct packed {
        logic [DELAY_W-1:0] delay_0;
        logic [DELAY_W-1:0] delay_1;
        logic [DELAY_W-1:0] delay_2;
    } fsm_t;

    typedef enum logic {
        ST_IDLE = 1'b0,
        ST_RUN  = 1'b1
    } seq_state_t;

    // Argument is payload[23:1]
    function automatic dpu_t unpack_dpu(input logic [22:0] fields);
        dpu_t d;
        d.option = fields[22:21];
        d.mode   = fields[20:16];
        d.imm    = fields[15:0];
        return d;
    endfunction

    // Argument is payload[21:1]
    function automatic fsm_t unpack_fsm(input logic [20:0] fields);
        fsm_t f;
        f.delay_0 = fields[20:14];
        f.delay_1 = fields[13:7];
        f.delay_2 = fields[6:0];
        return f;
    endfunction

    function automatic logic mode_active(input logic [4:0] mode);
        return (mode == MODE_ADD) || (mode == MODE_SUB) ||
               (mode == MODE_MUL) || (mode == MODE_MAC);
    endfunction

endpackage

// File: rtl/complex_round_sat.sv
// Reduces a wide signed value to OUT_W bits, either saturating at the
// signed limits or keeping the low bits (wrap).
module complex_round_sat #(
    parameter int IN_W  = 25,
    parameter int OUT_W = 16
) (
    input  logic signed [IN_W-1:0] value_in,
    input  logic                   sat,
    output logic [OUT_W-1:0]       value_out
);

    localparam logic [OUT_W-1:0] MAX_V = {1'b0, {(OUT_W-1){1'b1}}};
    localparam logic [OUT_W-1:0] MIN_V = {1'b1, {(OUT_W-1){1'b0}}};

    // The value fits iff every bit from the output sign bit upward agrees
    logic [IN_W-OUT_W:0] top_bits;
    logic                overflow;

    assign top_bits = value_in[IN_W-1:OUT_W-1];
    assign overflow = !((&top_bits) || !(|top_bits));

    always_comb begin
        value_out = value_in[OUT_W-1:0];
        if (sat && overflow) begin
            value_out = value_in[IN_W-1] ? MIN_V : MAX_V;
        end
    end

endmodule

// File: rtl/complex_mac_dpu.sv
// Complex fixed-point ADD/SUB/MUL/MAC unit driven by a per-option slot table
// and a delay-counting option sequencer, with a two-stage result pipeline.
module complex_mac_dpu
    import complex_mac_dpu_pkg::*;
#(
    parameter int WORD_BITWIDTH  = 32,
    parameter int FRAC_BITWIDTH  = 8,
    parameter int NUM_OPTIONS    = 4,
    parameter int ACC_GUARD_BITS = 4
) (
    input  logic                     clk,
    input  logic                     rst_n,
    input  logic                     instr_en,
    input  logic [26:0]              instr,
    input  logic                     activate,
    input  logic [WORD_BITWIDTH-1:0] word_data_in_0,
    input  logic [WORD_BITWIDTH-1:0] word_data_in_1,
    output logic [WORD_BITWIDTH-1:0] word_data_out,
    output logic                     out_valid
);

    localparam int H     = WORD_BITWIDTH / 2;
    localparam int F     = FRAC_BITWIDTH;
    localparam int OPT_W = (NUM_OPTIONS > 1) ? $clog2(NUM_OPTIONS) : 1;
    localparam int PW    = 2 * H;
    localparam int SW    = 2 * H + 1;
    localparam int MW    = SW - F;
    localparam int AW    = H + ACC_GUARD_BITS;
    localparam int RW0   = (MW > AW) ? MW : AW;
    localparam int RW    = (RW0 > H + 1) ? RW0 : H + 1;

    localparam logic [OPT_W-1:0]       LAST_OPT = OPT_W'(NUM_OPTIONS - 1);
    localparam logic signed [SW-1:0]   ROUND    = (F > 0) ? (SW'(1) << (F - 1)) : SW'(0);

    logic [2:0] opcode;
    dpu_t       dpu_w;
    fsm_t       fsm_w;
    logic       dpu_wr;
    logic       fsm_wr;

    assign opcode = instr[26:24];
    assign dpu_w  = unpack_dpu(instr[23:1]);
    assign fsm_w  = unpack_fsm(instr[21:1]);
    assign dpu_wr = instr_en && (opcode == OP_DPU);
    assign fsm_wr = instr_en && (opcode == OP_FSM);

    logic [DELAY_W-1:0] delay_reg [NUM_DELAYS];

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int i = 0; i < NUM_DELAYS; i++) delay_reg[i] <= '0;
        end else if (fsm_wr) begin
            delay_reg[0] <= fsm_w.delay_0;
            delay_reg[1] <= fsm_w.delay_1;
            delay_reg[2] <= fsm_w.delay_2;
        end
    end

    logic [4:0]  mode_slot [NUM_OPTIONS];
    logic [15:0] imm_slot  [NUM_OPTIONS];

    for (genvar gi = 0; gi < NUM_OPTIONS; gi++) begin : g_slot
        logic [4:0]  mode_reg;
        logic [15:0] imm_reg;

        always_ff @(posedge clk or negedge rst_n) begin
            if (!rst_n) begin
                mode_reg <= '0;
                imm_reg  <= '0;
            end else if (dpu_wr && (int'(dpu_w.option) == gi)) begin
                mode_reg <= dpu_w.mode;
                imm_reg  <= dpu_w.imm;
            end
        end

        assign mode_slot[gi] = mode_reg;
        assign imm_slot[gi]  = imm_reg;
    end

    seq_state_t         state_reg, state_next;
    logic [OPT_W-1:0]   opt_reg, opt_next;
    logic [DELAY_W-1:0] cnt_reg, cnt_next;
    logic               first_reg, first_next;
    logic [DELAY_W-1:0] next_delay;

    // Delay for option opt_reg+1; the final option always runs one cycle
    always_comb begin
        next_delay = '0;
        for (int i = 1; i < NUM_DELAYS; i++) begin
            if ((int'(opt_reg) + 1 == i) && (i < NUM_OPTIONS - 1)) next_delay = delay_reg[i];
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_reg <= ST_IDLE;
            opt_reg   <= '0;
            cnt_reg   <= '0;
            first_reg <= 1'b0;
        end else begin
            state_reg <= state_next;
            opt_reg   <= opt_next;
            cnt_reg   <= cnt_next;
            first_reg <= first_next;
        end
    end

    always_comb begin
        state_next = state_reg;
        opt_next   = opt_reg;
        cnt_next   = cnt_reg;
        first_next = 1'b0;
        if (activate) begin
            state_next = ST_RUN;
            opt_next   = '0;
            cnt_next   = (NUM_OPTIONS > 1) ? delay_reg[0] : '0;
            first_next = 1'b1;
        end else if (state_reg == ST_RUN) begin
            if (cnt_reg != '0) begin
                cnt_next = cnt_reg - DELAY_W'(1);
            end else if (opt_reg == LAST_OPT) begin
                state_next = ST_IDLE;
                opt_next   = '0;
            end else begin
                opt_next   = opt_reg + OPT_W'(1);
                cnt_next   = next_delay;
                first_next = 1'b1;
            end
        end
    end

    logic [WORD_BITWIDTH-1:0] a_s1, b_s1;
    logic [4:0]               mode_s1;
    logic [15:0]              imm_s1;
    logic                     run_s1;
    logic                     first_s1;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            a_s1     <= '0;
            b_s1     <= '0;
            mode_s1  <= '0;
            imm_s1   <= '0;
            run_s1   <= 1'b0;
            first_s1 <= 1'b0;
        end else begin
            a_s1     <= word_data_in_0;
            b_s1     <= word_data_in_1;
            mode_s1  <= mode_slot[opt_reg];
            imm_s1   <= imm_slot[opt_reg];
            run_s1   <= (state_reg == ST_RUN);
            first_s1 <= first_reg;
        end
    end

    // Index 1 is the real half, index 0 the imaginary half
    logic signed [H-1:0]  a_h [2];
    logic signed [H-1:0]  b_h [2];
    logic signed [AW-1:0] acc_reg  [2];
    logic signed [AW-1:0] acc_next [2];
    logic [H-1:0]         red_out  [2];

    assign a_h[1] = a_s1[2*H-1:H];
    assign a_h[0] = a_s1[H-1:0];
    assign b_h[1] = b_s1[2*H-1:H];
    assign b_h[0] = b_s1[H-1:0];

    for (genvar gi = 0; gi < 2; gi++) begin : g_half
        logic signed [H:0]    add_v, sub_v;
        logic signed [PW-1:0] p0, p1;
        logic signed [SW-1:0] sum_v, rnd_v, shf_v;
        logic signed [RW-1:0] acc_base, mac_sum, red_in;

        assign add_v = (H+1)'(a_h[gi]) + (H+1)'(b_h[gi]);
        assign sub_v = (H+1)'(a_h[gi]) - (H+1)'(b_h[gi]);

        if (gi == 1) begin : g_re
            assign p0    = PW'(a_h[1]) * PW'(b_h[1]);
            assign p1    = PW'(a_h[0]) * PW'(b_h[0]);
            assign sum_v = SW'(p0) - SW'(p1);
        end else begin : g_im
            assign p0    = PW'(a_h[1]) * PW'(b_h[0]);
            assign p1    = PW'(a_h[0]) * PW'(b_h[1]);
            assign sum_v = SW'(p0) + SW'(p1);
        end

        assign rnd_v = sum_v + ROUND;
        assign shf_v = rnd_v >>> F;

        // First MAC cycle of a clearing option loads the product
        assign acc_base     = (imm_s1[1] && first_s1) ? '0 : RW'(acc_reg[gi]);
        assign mac_sum      = acc_base + RW'(shf_v);
        assign acc_next[gi] = AW'(mac_sum);

        always_comb begin
            case (mode_s1)
                MODE_ADD: red_in = RW'(add_v);
                MODE_SUB: red_in = RW'(sub_v);
                MODE_MAC: red_in = RW'(acc_next[gi]);
                default:  red_in = RW'(shf_v);
            endcase
        end

        complex_round_sat #(
            .IN_W  (RW),
            .OUT_W (H)
        ) u_round_sat (
            .value_in  (red_in),
            .sat       (imm_s1[0]),
            .value_out (red_out[gi])
        );
    end

    logic                     valid_next;
    logic [WORD_BITWIDTH-1:0] out_reg;
    logic                     valid_reg;

    assign valid_next = run_s1 && mode_active(mode_s1);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            out_reg   <= '0;
            valid_reg <= 1'b0;
            for (int i = 0; i < 2; i++) acc_reg[i] <= '0;
        end else begin
            valid_reg <= valid_next;
            if (valid_next) out_reg <= {red_out[1], red_out[0]};
            if (run_s1 && (mode_s1 == MODE_MAC)) begin
                for (int i = 0; i < 2; i++) acc_reg[i] <= acc_next[i];
            end
        end
    end

    assign word_data_out = out_reg;
    assign out_valid     = valid_reg;

    logic unused_bits;
    assign unused_bits = ^{instr[0], imm_s1[15:2]};

endmodule

// File: tb/tb_complex_mac_dpu.sv
// Scoreboard bench for complex_mac_dpu: a reference model predicts each
// result (value and cycle) as operands are driven; a monitor pops and compares.
module tb_complex_mac_dpu;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        instr_en = 1'b0;
    logic [26:0] instr = '0;
    logic        activate = 1'b0;
    logic [31:0] word_data_in_0 = '0;
    logic [31:0] word_data_in_1 = '0;
    logic [31:0] word_data_out;
    logic        out_valid;

    always #5 clk = ~clk;

    complex_mac_dpu dut (
        .clk            (clk),
        .rst_n          (rst_n),
        .instr_en       (instr_en),
        .instr          (instr),
        .activate       (activate),
        .word_data_in_0 (word_data_in_0),
        .word_data_in_1 (word_data_in_1),
        .word_data_out  (word_data_out),
        .out_valid      (out_valid)
    );

    typedef struct {
        logic [31:0] data;
        int          cyc;
    } exp_t;

    exp_t        sb[$];
    logic [31:0] obs[$];
    exp_t        mon_e;
    logic [31:0] last_push = '0;
    int          n_cmp = 0;
    int          n_err = 0;
    int          cyc = 0;
    int          m_mode[4];
    int          m_imm[4];
    int          m_dly[3];
    longint      m_acc[2];

    task automatic check_val(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got %h expected %h (cycle %0d)", tag, got, exp, cyc);
        end
    endtask

    always @(posedge clk) begin
        cyc = cyc + 1;
        #1;
        if (out_valid) begin
            obs.push_back(word_data_out);
            $display("[%0d] out_valid data=%h", cyc, word_data_out);
            if (sb.size() == 0) begin
                check_val("spurious_valid", sb.size(), 1);
            end else begin
                mon_e = sb.pop_front();
                check_val("data", word_data_out, mon_e.data);
                check_val("cycle", cyc, mon_e.cyc);
            end
        end
    end

    function automatic logic [15:0] red16(input longint v, input bit sat);
        logic [15:0] r;
        r = v[15:0];
        if (sat && v > 32767) r = 16'h7FFF;
        else if (sat && v < -32768) r = 16'h8000;
        return r;
    endfunction

    function automatic longint wrap20(input longint v);
        logic [19:0] t;
        t = v[19:0];
        return longint'($signed(t));
    endfunction

    function automatic logic [31:0] model(input int mode, input int imm, input bit first,
                                          input logic [31:0] a, input logic [31:0] b);
        longint ar, ai, br, bi;
        longint v[2];
        ar = longint'($signed(a[31:16]));
        ai = longint'($signed(a[15:0]));
        br = longint'($signed(b[31:16]));
        bi = longint'($signed(b[15:0]));
        case (mode)
            1: begin v[1] = ar + br; v[0] = ai + bi; end
            2: begin v[1] = ar - br; v[0] = ai - bi; end
            default: begin
                v[1] = (ar * br - ai * bi + 128) >>> 8;
                v[0] = (ar * bi + ai * br + 128) >>> 8;
            end
        endcase
        if (mode == 10) begin
            for (int i = 0; i < 2; i++) begin
                if (imm[1] && first) m_acc[i] = 0;
                m_acc[i] = wrap20(m_acc[i] + v[i]);
                v[i] = m_acc[i];
            end
        end
        return {red16(v[1], imm[0]), red16(v[0], imm[0])};
    endfunction

    task automatic wr_dpu(input int opt, input int mode, input int imm);
        @(negedge clk);
        instr_en = 1'b1;
        instr = {3'd3, 2'(opt), 5'(mode), 16'(imm), 1'b0};
        @(negedge clk);
        instr_en = 1'b0;
        instr = '0;
        m_mode[opt] = mode;
        m_imm[opt] = imm;
    endtask

    task automatic wr_fsm(input int d0, input int d1, input int d2);
        @(negedge clk);
        instr_en = 1'b1;
        instr = {3'd2, 2'b00, 7'(d0), 7'(d1), 7'(d2), 1'b0};
        @(negedge clk);
        instr_en = 1'b0;
        instr = '0;
        m_dly[0] = d0;
        m_dly[1] = d1;
        m_dly[2] = d2;
    endtask

    task automatic cfg(input int m0, input int i0, input int m1, input int i1,
                       input int m2, input int i2, input int m3, input int i3,
                       input int d0, input int d1, input int d2);
        wr_dpu(0, m0, i0);
        wr_dpu(1, m1, i1);
        wr_dpu(2, m2, i2);
        wr_dpu(3, m3, i3);
        wr_fsm(d0, d1, d2);
    endtask

    // Called at a negedge: operands are sampled at the next edge, result one edge later
    task automatic drive_op(input int opt, input bit first, input logic [31:0] a, input logic [31:0] b);
        exp_t e;
        word_data_in_0 = a;
        word_data_in_1 = b;
        if (m_mode[opt] inside {1, 2, 7, 10}) begin
            e.data = model(m_mode[opt], m_imm[opt], first, a, b);
            e.cyc = cyc + 2;
            sb.push_back(e);
            last_push = e.data;
        end
    endtask

    task automatic drain();
        int n = 0;
        while (sb.size() != 0 && n < 20) begin
            @(negedge clk);
            n++;
        end
        check_val("drain", sb.size(), 0);
        repeat (2) @(negedge clk);
        check_val("hold_data", word_data_out, last_push);
        check_val("hold_valid", {31'b0, out_valid}, 0);
    endtask

    task automatic run_seq(input int restart_at, input bit rnd, input logic [31:0] fa, input logic [31:0] fb);
        int opts[$];
        int seq[$];
        bit firsts[$];
        int dl[4];
        logic [31:0] a, b;
        dl[0] = m_dly[0]; dl[1] = m_dly[1]; dl[2] = m_dly[2]; dl[3] = 0;
        for (int k = 0; k < 4; k++)
            for (int j = 0; j <= dl[k]; j++) opts.push_back(k);
        for (int i = 0; i < opts.size(); i++) begin
            seq.push_back(opts[i]);
            firsts.push_back(i == 0 || opts[i] != opts[i-1]);
            if (i == restart_at) break;
        end
        if (restart_at >= 0) begin
            for (int i = 0; i < opts.size(); i++) begin
                seq.push_back(opts[i]);
                firsts.push_back(i == 0 || opts[i] != opts[i-1]);
            end
        end
        obs.delete();
        @(negedge clk);
        activate = 1'b1;
        word_data_in_0 = fa;
        word_data_in_1 = fb;
        @(negedge clk);
        for (int i = 0; i < seq.size(); i++) begin
            a = rnd ? $urandom : fa;
            b = rnd ? $urandom : fb;
            activate = (i == restart_at);
            drive_op(seq[i], firsts[i], a, b);
            @(negedge clk);
        end
        activate = 1'b0;
        word_data_in_0 = '0;
        word_data_in_1 = '0;
        drain();
    endtask

    task automatic clear_model();
        sb.delete();
        for (int i = 0; i < 4; i++) begin m_mode[i] = 0; m_imm[i] = 0; end
        for (int i = 0; i < 3; i++) m_dly[i] = 0;
        m_acc[0] = 0;
        m_acc[1] = 0;
        last_push = '0;
    endtask

    initial begin
        #200000;
        $display("FAIL global_timeout: got no finish expected finish");
        $fatal(1, "timeout");
    end

    initial begin
        clear_model();
        repeat (2) @(negedge clk);
        check_val("reset_data", word_data_out, 32'h0);
        check_val("reset_valid", {31'b0, out_valid}, 0);
        rst_n = 1'b1;

        // ADD wrap, single-cycle option 0
        cfg(1, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0);
        run_seq(-1, 1'b0, 32'h0001_0002, 32'h0003_0004);
        check_val("add_lit", obs[0], 32'h0004_0006);

        // MUL (1+1j)^2
        cfg(7, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0);
        run_seq(-1, 1'b0, 32'h0100_0100, 32'h0100_0100);
        check_val("mul_lit", obs[0], 32'h0000_0200);

        // ADD overflow: option 0 saturates, option 1 wraps
        cfg(1, 1, 1, 0, 0, 0, 0, 0, 0, 0, 0);
        run_seq(-1, 1'b0, 32'h7FFF_0000, 32'h0001_0000);
        check_val("add_sat_lit", obs[0], 32'h7FFF_0000);
        check_val("add_wrap_lit", obs[1], 32'h8000_0000);

        // MAC with clear over a three-cycle option
        cfg(10, 2, 0, 0, 0, 0, 0, 0, 2, 0, 0);
        run_seq(-1, 1'b0, 32'h0100_0000, 32'h0100_0000);
        check_val("mac_lit0", obs[0], 32'h0100_0000);
        check_val("mac_lit1", obs[1], 32'h0200_0000);
        check_val("mac_lit2", obs[2], 32'h0300_0000);

        // Sequencer 2,0,1 with distinct modes, then restart inside option 2
        cfg(1, 0, 2, 1, 7, 1, 10, 2, 2, 0, 1);
        run_seq(-1, 1'b1, 32'h0, 32'h0);
        check_val("seq_count", obs.size(), 7);
        run_seq(4, 1'b1, 32'h0, 32'h0);
        check_val("restart_count", obs.size(), 12);

        // Mixed random run, MAC without clear and saturating MUL
        cfg(2, 0, 10, 1, 1, 1, 7, 1, 1, 3, 2);
        run_seq(-1, 1'b1, 32'h0, 32'h0);
        run_seq(-1, 1'b1, 32'h0, 32'h0);

        // Reset in the middle of a MAC option
        cfg(10, 0, 0, 0, 0, 0, 0, 0, 5, 0, 0);
        @(negedge clk);
        activate = 1'b1;
        @(negedge clk);
        activate = 1'b0;
        for (int i = 0; i < 3; i++) begin
            drive_op(0, i == 0, 32'h0100_0000, 32'h0100_0000);
            @(negedge clk);
        end
        #2;
        rst_n = 1'b0;
        clear_model();
        #1;
        check_val("midrst_data", word_data_out, 32'h0);
        check_val("midrst_valid", {31'b0, out_valid}, 0);
        repeat (2) @(negedge clk);
        rst_n = 1'b1;
        cfg(10, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0);
        run_seq(-1, 1'b0, 32'h0100_0000, 32'h0200_0000);
        check_val("post_rst_mac", obs[0], 32'h0200_0000);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule

// File: doc/complex_mac_dpu.md
COMPLEX_MAC_DPU -- requirements
Module: complex_mac_dpu

Interface
REQ-001 SHALL have parameter WORD_BITWIDTH, default 32, meaning the packed complex word width: real part in the upper half, imaginary part in the lower half.
REQ-002 SHALL have parameter FRAC_BITWIDTH, default 8, meaning fractional bits of each signed half (fixed point Q(H-F).F, where H = WORD_BITWIDTH/2 and F = FRAC_BITWIDTH).
REQ-003 SHALL have parameter NUM_OPTIONS, default 4, meaning the number of option slots and FSM states.
REQ-004 SHALL have parameter ACC_GUARD_BITS, default 4, meaning extra accumulator bits per half.
REQ-005 SHALL use one clock and an asynchronous, active-low reset.
REQ-006 SHALL have the following ports:
- clk, input, 1: clock.
- rst_n, input, 1: asynchronous active-low reset.
- instr_en, input, 1: instr is valid this cycle.
- instr, input, 27: opcode [26:24], payload [23:0].
- activate, input, 1: single-cycle pulse that starts an option sequence.
- word_data_in_0, input, WORD_BITWIDTH: operand A.
- word_data_in_1, input, WORD_BITWIDTH: operand B.
- word_data_out, output, WORD_BITWIDTH: result.
- out_valid, output, 1: word_data_out carries a fresh result.

Function
REQ-007 SHALL decode opcode 3 (DPU) as follows: option [23:22], mode [21:17], immediate [16:1]. It writes mode and immediate into slot[option] at the next edge.
REQ-008 SHALL decode opcode 2 (FSM) as follows: delay_0 [21:15], delay_1 [14:8], delay_2 [7:1]. It writes the delay registers at the next edge. All other opcodes are ignored.
REQ-009 SHALL use these mode encodings: 0 NOP, 1 ADD, 2 SUB, 7 MUL, 10 MAC. Any other value behaves as NOP.
REQ-010 SHALL use these immediate bits: immediate[0] selects saturate (1) or wrap (0); immediate[1] clears the accumulator on option entry.
REQ-011 SHALL implement the sequencer states IDLE and RUN, with a current option index and a delay counter.
- IDLE: activate -> RUN, option 0, counter = delay_0.
- RUN, counter != 0: decrement the counter.
- RUN, counter == 0, option k < NUM_OPTIONS-1: move to option k+1 and load delay_(k+1).
- Last option: its delay is 0, so it lasts 1 cycle, then -> IDLE.
- Option k therefore lasts delay_k+1 cycles.
REQ-012 SHALL restart at option 0 with delay_0 when activate arrives during RUN.
REQ-013 SHALL apply an FSM instruction received during RUN to later loads only; the running counter is not altered.
REQ-014 SHALL apply a DPU write to the currently active slot from the next cycle.
REQ-015 SHALL register both operands, together with the active slot's mode and immediate and a RUN flag (stage 1). It SHALL compute and register the result and out_valid (stage 2). Latency: operands sampled at edge N appear at edge N+1.
REQ-016 SHALL assert out_valid iff the stage-1 RUN flag is set and the stage-1 mode is not NOP. word_data_out holds its last value when out_valid = 0.
REQ-017 SHALL compute ADD and SUB per half as H+1-bit signed results, then saturate or wrap to H bits.
REQ-018 SHALL compute MUL as (ac - bd) + j(ad + bc):
- products are full 2H-bit signed;
- each sum is formed at 2H+1 bits;
- rounding adds 2^(F-1), then arithmetic shift right by F;
- the result is then saturated or wrapped to H bits.
REQ-019 SHALL implement MAC as accumulator += MUL result before H-bit reduction. The accumulator is H+ACC_GUARD_BITS wide per half and wraps internally. The output is acc saturated or wrapped to H bits.
REQ-020 SHALL clear the accumulator in the cycle the MAC product is added when immediate[1] is set and that cycle is the first cycle of the option; the first product is then loaded rather than added.
REQ-021 SHALL saturate to +(2^(H-1)-1) and -2^(H-1).

Reset
REQ-022 SHALL, on rst_n low, clear the following to 0: state (IDLE), option, counter, delays, slots, pipeline registers, accumulator, word_data_out and out_valid. This applies at any time, including mid-sequence.

Structure
REQ-023 SHALL place the following in a shared package: the opcode and mode constants, the dpu_t and fsm_t packed structs, and their unpack functions.
REQ-024 SHALL put the H-bit saturate/wrap reduction in one sub-module, complex_round_sat, instantiated per half.

Verification
REQ-025 ADD, wrap: 0x0001_0002 + 0x0003_0004 in RUN -> 0x0004_0006 with out_valid, one cycle after the operand sample.
REQ-026 MUL: 0x0100_0100 x 0x0100_0100 (1+1j squared, F=8) -> 0x0000_0200.
REQ-027 ADD 0x7FFF_0000 + 0x0001_0000: saturate -> 0x7FFF_0000; wrap -> 0x8000_0000.
REQ-028 MAC with clear bit set, option active 3 cycles, 0x0100_0000 x 0x0100_0000 each cycle -> outputs 0x0100_0000, 0x0200_0000, 0x0300_0000.
REQ-029 FSM delays 2,0,1, then activate -> option 0 for 3 cycles, 1 for 1, 2 for 2, 3 for 1, then IDLE. A second activate mid-option-2 -> restart at option 0.
REQ-030 rst_n low mid-MAC -> outputs 0 immediately. After release, a MAC without the clear bit starts from accumulator 0.
